// File: rtl/demux_1_8_scheduler.sv
// 1:8 demux scheduler: takes one word over a valid/ready handshake, holds it,
// and offers it to one channel picked by round-robin or a directed select.
module demux_1_8_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Enable_In,
    input  logic                   Mode_In,
    input  logic [2:0]             Dir_Select_In,
    input  logic [7:0]             Mask_In,
    input  logic [DATA_WIDTH-1:0]  Data_In,
    input  logic                   Valid_In,
    output logic                   Ready_Out,
    output logic [DATA_WIDTH-1:0]  Data_Out,
    output logic [7:0]             Valid_Out,
    input  logic [7:0]             Ready_In,
    output logic [2:0]             Select_Out,
    output logic [COUNT_WIDTH-1:0] Transfer_Count_Out
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [2:0] rr_ptr;
    logic [2:0] rr_pick;
    logic       rr_found;
    logic [2:0] next_sel;
    logic       channel_ok;
    logic       held_rr;

    // First usable channel at or after the pointer, wrapping 7 -> 0.
    always_comb begin
        rr_pick  = rr_ptr;
        rr_found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!rr_found && Mask_In[rr_ptr + 3'(k)]) begin
                rr_pick  = rr_ptr + 3'(k);
                rr_found = 1'b1;
            end
        end
    end

    assign channel_ok = Mode_In ? Mask_In[Dir_Select_In] : (|Mask_In);
    assign next_sel   = Mode_In ? Dir_Select_In : rr_pick;
    assign Ready_Out  = !Reset_In && (state == IDLE) && Enable_In && channel_ok;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            held_rr            <= 1'b0;
            Data_Out           <= '0;
            Valid_Out          <= '0;
            Select_Out         <= '0;
            Transfer_Count_Out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Valid_In && Ready_Out) begin
                        Data_Out   <= Data_In;
                        Select_Out <= next_sel;
                        Valid_Out  <= 8'd1 << next_sel;
                        held_rr    <= !Mode_In;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // Only the offered channel's ready counts; mode/mask changes are ignored here.
                    if (Ready_In[Select_Out]) begin
                        Transfer_Count_Out <= Transfer_Count_Out + 1'b1;
                        if (held_rr)
                            rr_ptr <= Select_Out + 3'd1;
                        Valid_Out  <= '0;
                        Select_Out <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1_8_scheduler.sv
// Directed bench for demux_1_8_scheduler: transaction-level model checked every
// cycle, plus literal expectations for channel order, counts and reset values.
module tb_demux_1_8_scheduler;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1, mode = 1'b0, vin = 1'b0, rout;
    logic [2:0]    dir = 3'd0, sel;
    logic [7:0]    mask = 8'hFF, rdy_in = 8'hFF, vout;
    logic [DW-1:0] din = '0, dout;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    demux_1_8_scheduler #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
        .Dir_Select_In(dir), .Mask_In(mask), .Data_In(din), .Valid_In(vin),
        .Ready_Out(rout), .Data_Out(dout), .Valid_Out(vout), .Ready_In(rdy_in),
        .Select_Out(sel), .Transfer_Count_Out(cnt)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Transaction model: a held word (busy/channel/data), a pointer, a count, a log.
    bit       m_busy = 0, m_rr = 0;
    int       m_ch = 0, m_ptr = 0, m_cnt = 0;
    int       m_data = 0;
    int       log_q[$];

    function automatic int rr_find(int p, logic [7:0] m);
        for (int k = 0; k < 8; k++)
            if (m[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    function automatic bit exp_ready();
        bit ok;
        ok = mode ? mask[dir] : (mask != 8'd0);
        return !rst && !m_busy && en && ok;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_rr = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (vin && exp_ready()) begin
                m_busy = 1;
                m_data = int'(din);
                m_ch   = mode ? int'(dir) : rr_find(m_ptr, mask);
                m_rr   = !mode;
            end
        end else if (rdy_in[m_ch]) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            log_q.push_back(m_ch);
            if (m_rr) m_ptr = (m_ch + 1) % 8;
            m_busy = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ready", int'(rout), int'(exp_ready()));
        chk("valid_out", int'(vout), m_busy ? (1 << m_ch) : 0);
        chk("select", int'(sel), m_busy ? m_ch : 0);
        chk("count", int'(cnt), m_cnt);
        if (m_busy) chk("data", int'(dout), m_data);
    end

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        log_q.delete();
    endtask

    initial begin
        int e_rr[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        int e_mk[4]  = '{2, 5, 7, 2};

        #2;
        chk("rst_ready", int'(rout), 0);
        chk("rst_valid", int'(vout), 0);
        chk("rst_data", int'(dout), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_cnt", int'(cnt), 0);
        @(negedge clk) rst = 1'b0;

        // Round-robin, all channels usable and ready
        vin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 8'(8'h10 + i);
            @(negedge clk);
        end
        vin = 1'b0;
        chk("rr_len", log_q.size(), 10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) chk("rr_order", log_q[i], e_rr[i]);
        chk("rr_cnt", int'(cnt), 10);

        // Sparse mask from pointer 0
        pulse_reset();
        mask = 8'b1010_0100;
        vin  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'(8'h30 + i);
            @(negedge clk);
        end
        vin = 1'b0;
        chk("mask_len", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("mask_order", log_q[i], e_mk[i]);
        chk("mask_cnt", int'(cnt), 4);

        // Directed to 6, stalled; retarget attempts and other readies ignored
        mode = 1'b1; dir = 3'd6; mask = 8'hFF; rdy_in = 8'h00; din = 8'hA5; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0; din = 8'h00; mask = 8'h00; dir = 3'd1; mode = 1'b0; rdy_in = 8'hBF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dir_hold_valid", int'(vout), 8'h40);
            chk("dir_hold_data", int'(dout), 8'hA5);
            chk("dir_hold_ready", int'(rout), 0);
        end
        rdy_in = 8'h40;
        @(negedge clk);
        chk("dir_done_valid", int'(vout), 0);
        chk("dir_done_cnt", int'(cnt), 5);
        chk("dir_done_ch", log_q.size() > 0 ? log_q[$] : -1, 6);

        // Directed to a masked channel: never accepted
        mask = 8'hF7; mode = 1'b1; dir = 3'd3; rdy_in = 8'hFF; vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("masked_ready", int'(rout), 0);
            chk("masked_valid", int'(vout), 0);
        end
        vin = 1'b0;
        chk("masked_cnt", int'(cnt), 5);

        // Enable dropped during HOLD; pointer still 3 from the sparse-mask run
        mode = 1'b0; mask = 8'hFF; rdy_in = 8'h00; din = 8'h3C; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_hold_valid", int'(vout), 8'h08);
        rdy_in = 8'hFF;
        @(negedge clk);
        chk("en_done_valid", int'(vout), 0);
        chk("en_done_ready", int'(rout), 0);
        chk("en_done_cnt", int'(cnt), 6);

        // Count wrap: 10 more transfers -> 16 wraps to 0, then 1
        en = 1'b1; vin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 8'(8'hC0 + i);
            @(negedge clk);
        end
        chk("wrap_zero", int'(cnt), 0);
        repeat (2) @(negedge clk);
        vin = 1'b0;
        chk("wrap_one", int'(cnt), 1);

        // Reset while holding a word
        rdy_in = 8'h00; din = 8'h77; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", int'(vout != 8'h00), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(vout), 0);
        chk("midrst_cnt", int'(cnt), 0);
        chk("midrst_ready", int'(rout), 0);
        chk("midrst_sel", int'(sel), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
